// File: rtl/stc_pkg.sv
// Shared types for the space-time computing blocks: edge-encoding modes and
// the idle line level each mode implies.
package stc_pkg;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_PULSE   = 2'd2
    } edge_mode_e;

    // Level a lane sits at when it carries no event (infinity or tick 0).
    function automatic logic idle_level(input edge_mode_e mode);
        return (mode == EDGE_FALLING);
    endfunction

endpackage

// File: rtl/lane_shaper.sv
// One temporal lane: turns an active value plus the upcoming tick into a
// registered, glitch-free race-logic line.
module lane_shaper
    import stc_pkg::*;
#(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter edge_mode_e  EDGE_MODE         = EDGE_RISING,
    localparam int unsigned VAL_W            = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] tick_next,
    input  logic [VAL_W-1:0] val,
    input  logic             inf,
    output logic             lane_out
);

    logic lane_d, lane_q;
    logic started;
    logic in_window;

    // Evaluated against the next tick so the flop output lines up with tick.
    // Tick 0 never satisfies started because events fire at v+1 >= 1.
    always_comb begin
        started   = 1'b0;
        in_window = 1'b0;
        if (!inf) begin
            started   = (32'(tick_next) >= 32'(val) + 32'd1);
            in_window = started && (32'(tick_next) <= 32'(val) + PULSE_WIDTH);
        end
        lane_d = idle_level(EDGE_MODE);
        unique case (EDGE_MODE)
            EDGE_RISING:  lane_d = started;
            EDGE_FALLING: lane_d = !started;
            EDGE_PULSE:   lane_d = in_window;
            default:      lane_d = idle_level(EDGE_MODE);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= idle_level(EDGE_MODE);
        end else begin
            lane_q <= lane_d;
        end
    end

    assign lane_out = lane_q;

endmodule

// File: rtl/temporal_encoder.sv
// Binary-to-race-logic transmitter: double-buffered lane values are replayed
// as edge-timed spikes once per gamma cycle, with a gamma-start set pulse.
module temporal_encoder
    import stc_pkg::*;
#(
    parameter int unsigned NUM_LANES         = 2,
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter int unsigned EDGE_MODE         = 0,
    localparam int unsigned VAL_W            = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES*VAL_W-1:0] in_val,
    input  logic [NUM_LANES-1:0]       in_inf,
    output logic                       set,
    output logic [VAL_W-1:0]           tick,
    output logic                       gamma_valid,
    output logic [NUM_LANES-1:0]       lane_out
);

    localparam logic [VAL_W-1:0] TickLast = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam edge_mode_e       Mode     = edge_mode_e'(EDGE_MODE[1:0]);

    logic [VAL_W-1:0]           tick_d, tick_q;
    logic                       set_d, set_q;
    logic                       gv_d, gv_q;
    logic                       rdy_d, rdy_q;
    logic                       shadow_full_d, shadow_full_q;
    logic [NUM_LANES*VAL_W-1:0] shadow_val_d, shadow_val_q;
    logic [NUM_LANES-1:0]       shadow_inf_d, shadow_inf_q;
    logic [NUM_LANES*VAL_W-1:0] act_val_d, act_val_q;
    logic [NUM_LANES-1:0]       act_inf_d, act_inf_q;

    logic                       wrap;
    logic                       hs;
    logic [NUM_LANES-1:0]       in_inf_n;

    // Values that would fire at tick G or later are stored as infinity.
    always_comb begin
        in_inf_n = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            in_inf_n[i] = in_inf[i] || (in_val[i*VAL_W +: VAL_W] >= TickLast);
        end
    end

    always_comb begin
        wrap          = (tick_q == TickLast);
        hs            = in_valid && rdy_q;
        tick_d        = wrap ? '0 : tick_q + 1'b1;
        set_d         = wrap;
        gv_d          = gv_q;
        shadow_full_d = shadow_full_q;
        shadow_val_d  = shadow_val_q;
        shadow_inf_d  = shadow_inf_q;
        act_val_d     = act_val_q;
        act_inf_d     = act_inf_q;

        if (wrap) begin
            if (shadow_full_q) begin
                act_val_d     = shadow_val_q;
                act_inf_d     = shadow_inf_q;
                gv_d          = 1'b1;
                shadow_full_d = hs;
                if (hs) begin
                    shadow_val_d = in_val;
                    shadow_inf_d = in_inf_n;
                end
            end else if (hs) begin
                act_val_d = in_val;
                act_inf_d = in_inf_n;
                gv_d      = 1'b1;
            end else begin
                act_val_d = '0;
                act_inf_d = '1;
                gv_d      = 1'b0;
            end
        end else if (hs) begin
            shadow_val_d  = in_val;
            shadow_inf_d  = in_inf_n;
            shadow_full_d = 1'b1;
        end

        // Registered form of !shadow_full || tick == G-1 for the coming cycle.
        rdy_d = !shadow_full_d || (tick_d == TickLast);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q        <= TickLast;
            set_q         <= 1'b0;
            gv_q          <= 1'b0;
            rdy_q         <= 1'b1;
            shadow_full_q <= 1'b0;
            shadow_val_q  <= '0;
            shadow_inf_q  <= '1;
            act_val_q     <= '0;
            act_inf_q     <= '1;
        end else begin
            tick_q        <= tick_d;
            set_q         <= set_d;
            gv_q          <= gv_d;
            rdy_q         <= rdy_d;
            shadow_full_q <= shadow_full_d;
            shadow_val_q  <= shadow_val_d;
            shadow_inf_q  <= shadow_inf_d;
            act_val_q     <= act_val_d;
            act_inf_q     <= act_inf_d;
        end
    end

    // Lanes see the old active set while tick_d is 0, but tick 0 is idle anyway.
    for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
        lane_shaper #(
            .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
            .PULSE_WIDTH      (PULSE_WIDTH),
            .EDGE_MODE        (Mode)
        ) u_lane_shaper (
            .clk      (clk),
            .rst      (rst),
            .tick_next(tick_d),
            .val      (act_val_q[i*VAL_W +: VAL_W]),
            .inf      (act_inf_q[i]),
            .lane_out (lane_out[i])
        );
    end

    assign in_ready    = rdy_q;
    assign set         = set_q;
    assign tick        = tick_q;
    assign gamma_valid = gv_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench: one encoder per edge mode, all fed the same vectors, with
// hand-derived per-tick expectations for control outputs and every lane.
module tb_temporal_encoder;

    localparam int G  = 16;
    localparam int VW = 4;
    localparam int NL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [NL*VW-1:0] in_val = '0;
    logic [NL-1:0] in_inf = '0;

    logic          rdy_r, set_r, gv_r, rdy_f, set_f, gv_f, rdy_p, set_p, gv_p;
    logic [VW-1:0] tick_r, tick_f, tick_p;
    logic [NL-1:0] lo_r, lo_f, lo_p;

    logic [6:0]    ctl_r, ctl_f, ctl_p;
    logic [26:0]   obs;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = G - 1;

    always #5 clk = ~clk;

    temporal_encoder #(.NUM_LANES(NL), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(8), .EDGE_MODE(0)) u_rise (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r), .in_val(in_val),
        .in_inf(in_inf), .set(set_r), .tick(tick_r), .gamma_valid(gv_r), .lane_out(lo_r)
    );
    temporal_encoder #(.NUM_LANES(NL), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(8), .EDGE_MODE(1)) u_fall (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_f), .in_val(in_val),
        .in_inf(in_inf), .set(set_f), .tick(tick_f), .gamma_valid(gv_f), .lane_out(lo_f)
    );
    temporal_encoder #(.NUM_LANES(NL), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(8), .EDGE_MODE(2)) u_pulse (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_p), .in_val(in_val),
        .in_inf(in_inf), .set(set_p), .tick(tick_p), .gamma_valid(gv_p), .lane_out(lo_p)
    );

    assign ctl_r = {tick_r, set_r, gv_r, rdy_r};
    assign ctl_f = {tick_f, set_f, gv_f, rdy_f};
    assign ctl_p = {tick_p, set_p, gv_p, rdy_p};
    assign obs   = {ctl_r, ctl_f, ctl_p, lo_r, lo_f, lo_p};

    task automatic step();
        @(posedge clk);
        #1;
        t = (t == G - 1) ? 0 : t + 1;
    endtask

    task automatic goto_tick(input int n);
        for (int i = 0; i < 2 * G && t != n; i++) step();
    endtask

    task automatic test_reset();
        logic [6:0] c;
        logic [1:0] r, p;
        rst = 1'b1;
        #1;
        t = G - 1;
        c = {4'd15, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== {c, c, c, 2'b00, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_async got %h want %h", obs, {c, c, c, 2'b00, 2'b11, 2'b00});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== {c, c, c, 2'b00, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_held got %h want %h", obs, {c, c, c, 2'b00, 2'b11, 2'b00});
        end
        rst = 1'b0;
        step();
        r = 2'b00;
        p = 2'b00;
        for (int k = 0; k < G; k++) begin
            c = {4'(k), 1'(k == 0), 1'b0, 1'b1};
            n_checks++;
            if (obs !== {c, c, c, r, ~r, p}) begin
                n_fail++;
                $display("FAIL idle_gamma t=%0d got %h want %h", k, obs, {c, c, c, r, ~r, p});
            end
            step();
        end
    endtask

    task automatic test_mode0_rise();
        logic [6:0] c;
        logic [1:0] r, p;
        goto_tick(5);
        n_checks++;
        if (rdy_r !== 1'b1) begin
            n_fail++;
            $display("FAIL m0_ready_before got %b want 1", rdy_r);
        end
        in_valid = 1'b1;
        in_val   = {4'd10, 4'd3};
        in_inf   = 2'b00;
        step();
        in_valid = 1'b0;
        while (t != G - 1) begin
            n_checks++;
            if ({rdy_r, gv_r, lo_r} !== 4'b0000) begin
                n_fail++;
                $display("FAIL m0_shadow_wait t=%0d got %b want 0000", t, {rdy_r, gv_r, lo_r});
            end
            step();
        end
        n_checks++;
        if ({rdy_r, gv_r} !== 2'b10) begin
            n_fail++;
            $display("FAIL m0_ready_last got %b want 10", {rdy_r, gv_r});
        end
        step();
        for (int k = 0; k < G; k++) begin
            r = {k >= 11, k >= 4};
            p = {k >= 11, k >= 4 && k <= 11};
            c = {4'(k), 1'(k == 0), 1'b1, 1'b1};
            n_checks++;
            if (obs !== {c, c, c, r, ~r, p}) begin
                n_fail++;
                $display("FAIL m0_play t=%0d got %h want %h", k, obs, {c, c, c, r, ~r, p});
            end
            step();
        end
        c = {4'd0, 1'b1, 1'b0, 1'b1};
        n_checks++;
        if (obs !== {c, c, c, 2'b00, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL m0_after got %h want %h", obs, {c, c, c, 2'b00, 2'b11, 2'b00});
        end
    endtask

    task automatic test_mode1_fall();
        logic [6:0] c;
        logic [1:0] r, p;
        goto_tick(3);
        in_valid = 1'b1;
        in_val   = {4'd5, 4'd0};
        in_inf   = 2'b10;
        step();
        in_valid = 1'b0;
        in_inf   = 2'b00;
        goto_tick(G - 1);
        step();
        for (int k = 0; k < G; k++) begin
            r = {1'b0, k >= 1};
            p = {1'b0, k >= 1 && k <= 8};
            c = {4'(k), 1'(k == 0), 1'b1, 1'b1};
            n_checks++;
            if (obs !== {c, c, c, r, ~r, p}) begin
                n_fail++;
                $display("FAIL m1_play t=%0d got %h want %h", k, obs, {c, c, c, r, ~r, p});
            end
            step();
        end
    endtask

    task automatic test_mode2_pulse();
        logic [6:0] c;
        logic [1:0] r, p;
        goto_tick(8);
        in_valid = 1'b1;
        in_val   = {4'd2, 4'd12};
        step();
        in_valid = 1'b0;
        goto_tick(G - 1);
        step();
        for (int k = 0; k < G; k++) begin
            r = {k >= 3, k >= 13};
            p = {k >= 3 && k <= 10, k >= 13};
            c = {4'(k), 1'(k == 0), 1'b1, 1'b1};
            n_checks++;
            if (obs !== {c, c, c, r, ~r, p}) begin
                n_fail++;
                $display("FAIL m2_play t=%0d got %h want %h", k, obs, {c, c, c, r, ~r, p});
            end
            step();
        end
    endtask

    task automatic test_bypass();
        logic [6:0] c;
        logic [1:0] r, p;
        goto_tick(G - 1);
        in_valid = 1'b1;
        in_val   = {4'd0, 4'd5};
        step();
        in_valid = 1'b0;
        for (int k = 0; k < G; k++) begin
            r = {k >= 1, k >= 6};
            p = {k >= 1 && k <= 8, k >= 6 && k <= 13};
            c = {4'(k), 1'(k == 0), 1'b1, 1'b1};
            n_checks++;
            if (obs !== {c, c, c, r, ~r, p}) begin
                n_fail++;
                $display("FAIL bypass_play t=%0d got %h want %h", k, obs, {c, c, c, r, ~r, p});
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] c;
        logic [1:0] r, p;
        goto_tick(2);
        in_valid = 1'b1;
        in_val   = {4'd7, 4'd15};
        step();
        in_val = {4'd14, 4'd1};
        while (t != G - 1) begin
            n_checks++;
            if (rdy_r !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_ready_low t=%0d got %b want 0", t, rdy_r);
            end
            step();
        end
        n_checks++;
        if (rdy_r !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_last got %b want 1", rdy_r);
        end
        step();
        in_valid = 1'b0;
        for (int k = 0; k < G; k++) begin
            r = {k >= 8, 1'b0};
            p = {k >= 8, 1'b0};
            c = {4'(k), 1'(k == 0), 1'b1, 1'(k == G - 1)};
            n_checks++;
            if (obs !== {c, c, c, r, ~r, p}) begin
                n_fail++;
                $display("FAIL b2b_first t=%0d got %h want %h", k, obs, {c, c, c, r, ~r, p});
            end
            step();
        end
        for (int k = 0; k < G; k++) begin
            r = {k >= 15, k >= 2};
            p = {k >= 15, k >= 2 && k <= 9};
            c = {4'(k), 1'(k == 0), 1'b1, 1'b1};
            n_checks++;
            if (obs !== {c, c, c, r, ~r, p}) begin
                n_fail++;
                $display("FAIL b2b_second t=%0d got %h want %h", k, obs, {c, c, c, r, ~r, p});
            end
            step();
        end
        c = {4'd0, 1'b1, 1'b0, 1'b1};
        n_checks++;
        if (obs !== {c, c, c, 2'b00, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL b2b_no_repeat got %h want %h", obs, {c, c, c, 2'b00, 2'b11, 2'b00});
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] c;
        goto_tick(2);
        in_valid = 1'b1;
        in_val   = {4'd4, 4'd3};
        step();
        in_valid = 1'b0;
        goto_tick(G - 1);
        step();
        step();
        in_valid = 1'b1;
        in_val   = {4'd1, 4'd1};
        step();
        in_valid = 1'b0;
        goto_tick(7);
        n_checks++;
        if ({gv_r, lo_r, lo_f} !== 5'b11100) begin
            n_fail++;
            $display("FAIL rmid_pre got %b want 11100", {gv_r, lo_r, lo_f});
        end
        rst = 1'b1;
        #1;
        t = G - 1;
        c = {4'd15, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== {c, c, c, 2'b00, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL rmid_async got %h want %h", obs, {c, c, c, 2'b00, 2'b11, 2'b00});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        for (int k = 0; k < G; k++) begin
            c = {4'(k), 1'(k == 0), 1'b0, 1'b1};
            n_checks++;
            if (obs !== {c, c, c, 2'b00, 2'b11, 2'b00}) begin
                n_fail++;
                $display("FAIL rmid_restart t=%0d got %h want %h", k, obs,
                         {c, c, c, 2'b00, 2'b11, 2'b00});
            end
            step();
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_mode0_rise();
        test_mode1_fall();
        test_mode2_pulse();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
